i2c_codec_slave: RTL and testbench

Receive-side I2C responder that emulates the write-only register port of the audio codec. It decodes the 3-byte write transaction (device address, then a 16-bit register word) issued by the I2C configuration master. It presents each completed register write as a one-cycle strobe, so that a codec model or a shadow register bank can track the configuration. It sits on the board-level I2C_SCLK/I2C_SDAT pair and is clocked by the system clock, not by SCL.

---
 rtl/i2c_pkg.sv | 13 +
 rtl/i2c_codec_slave_if.sv | 14 +
 rtl/i2c_line_filter.sv | 37 +++
 rtl/i2c_codec_slave.sv | 100 ++++++++++
 tb/tb_i2c_codec_slave.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the codec-side I2C responder
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE
    } i2cState_t;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h1A;
    localparam int         BIT_COUNT        = 8;
    localparam int         REG_ADDR_W       = 7;
    localparam int         REG_DATA_W       = 9;

endpackage

// File: rtl/i2c_codec_slave_if.sv
// rtl/i2c_codec_slave_if.sv - SCL input and register-write outputs of the codec responder
interface i2c_codec_slave_if;
    import i2c_pkg::*;

    logic                  I2C_SCLK;
    logic                  oREG_WE;
    logic [REG_ADDR_W-1:0] oREG_ADDR;
    logic [REG_DATA_W-1:0] oREG_DATA;
    logic                  oBUSY;

    modport slave  (input  I2C_SCLK, output oREG_WE, output oREG_ADDR, output oREG_DATA, output oBUSY);
    modport master (output I2C_SCLK, input  oREG_WE, input  oREG_ADDR, input  oREG_DATA, input  oBUSY);

endinterface

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - two-flop synchronizer followed by a FILTER_LEN-sample glitch filter
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic rawLine,
    output logic filtLevel
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] agreeCnt;

    // Idle I2C lines are pulled high, so everything resets to 1.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            filtLevel <= 1'b1;
            agreeCnt  <= '0;
        end else begin
            sync1 <= rawLine;
            sync2 <= sync1;
            if (sync2 == filtLevel) begin
                agreeCnt <= '0;
            end else if (agreeCnt == CW'(FILTER_LEN - 1)) begin
                filtLevel <= sync2;
                agreeCnt  <= '0;
            end else begin
                agreeCnt <= agreeCnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_codec_slave.sv
// rtl/i2c_codec_slave.sv - write-only codec register port: decodes 3-byte I2C writes into strobes
module i2c_codec_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = DEFAULT_DEV_ADDR,
    parameter int         FILTER_LEN = 3
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    inout  wire              I2C_SDAT,
    i2c_codec_slave_if.slave bus
);
    logic sclF, sdaF, sclPrev, sdaPrev;
    logic sclRise, sclFall, startDet, stopDet;
    logic inByte, inAck, byteFull;
    logic sdaDrive;
    logic [3:0] bitCnt;
    logic [7:0] shiftReg;
    logic [7:0] byte1;
    i2cState_t state, stateNext;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) uSclFilter (
        .iCLK(iCLK), .iRST_N(iRST_N), .rawLine(bus.I2C_SCLK), .filtLevel(sclF)
    );
    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) uSdaFilter (
        .iCLK(iCLK), .iRST_N(iRST_N), .rawLine(I2C_SDAT), .filtLevel(sdaF)
    );

    assign sclRise  = sclF & ~sclPrev;
    assign sclFall  = ~sclF & sclPrev;
    assign startDet = sclF & sclPrev & sdaPrev & ~sdaF;
    assign stopDet  = sclF & sclPrev & ~sdaPrev & sdaF;
    assign inByte   = state inside {ADDR, BYTE1, BYTE2};
    assign inAck    = state inside {ACK_A, ACK_1, ACK_2};
    assign byteFull = (bitCnt == 4'(BIT_COUNT));

    assign I2C_SDAT = sdaDrive ? 1'b0 : 1'bz;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state <= IDLE;
        else         state <= stateNext;
    end

    // Bus conditions override everything; otherwise bytes close on the falling edge after bit 7.
    always_comb begin
        stateNext = state;
        if (stopDet) begin
            stateNext = IDLE;
        end else if (startDet) begin
            stateNext = ADDR;
        end else begin
            case (state)
                ADDR:   if (sclFall && byteFull)
                            stateNext = (shiftReg == {DEV_ADDR, 1'b0}) ? ACK_A : IGNORE;
                BYTE1:  if (sclFall && byteFull) stateNext = ACK_1;
                BYTE2:  if (sclFall && byteFull) stateNext = ACK_2;
                ACK_A:  if (sclFall) stateNext = BYTE1;
                ACK_1:  if (sclFall) stateNext = BYTE2;
                ACK_2:  if (sclFall) stateNext = BYTE1;
                default: stateNext = state;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sclPrev       <= 1'b1;
            sdaPrev       <= 1'b1;
            sdaDrive      <= 1'b0;
            bitCnt        <= '0;
            shiftReg      <= '0;
            byte1         <= '0;
            bus.oREG_WE   <= 1'b0;
            bus.oREG_ADDR <= '0;
            bus.oREG_DATA <= '0;
            bus.oBUSY     <= 1'b0;
        end else begin
            sclPrev     <= sclF;
            sdaPrev     <= sdaF;
            sdaDrive    <= stateNext inside {ACK_A, ACK_1, ACK_2};
            bus.oBUSY   <= stateNext inside {ACK_A, BYTE1, ACK_1, BYTE2, ACK_2};
            bus.oREG_WE <= (stateNext == ACK_2) && (state != ACK_2);
            if ((stateNext == ACK_1) && (state != ACK_1))
                byte1 <= shiftReg;
            if ((stateNext == ACK_2) && (state != ACK_2)) begin
                bus.oREG_ADDR <= byte1[7:1];
                bus.oREG_DATA <= {byte1[0], shiftReg};
            end
            if (startDet || stopDet) begin
                bitCnt <= '0;
            end else if (inByte && sclRise && !byteFull) begin
                shiftReg <= {shiftReg[6:0], sdaF};
                bitCnt   <= bitCnt + 4'd1;
            end else if (inAck && sclFall) begin
                bitCnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_codec_slave.sv
// tb/tb_i2c_codec_slave.sv - directed and randomized I2C write transactions against a byte-level model
module tb_i2c_codec_slave;

    localparam int Q = 20;

    typedef struct packed {
        logic [6:0] a;
        logic [8:0] d;
    } commit_t;

    logic iCLK = 1'b0;
    logic iRST_N = 1'b0;
    logic tbSdaLow = 1'b0;
    logic sclPin = 1'b1;
    wire  I2C_SDAT;

    always #10 iCLK = ~iCLK;

    assign I2C_SDAT = tbSdaLow ? 1'b0 : 1'bz;
    pullup (I2C_SDAT);

    i2c_codec_slave_if bus ();
    assign bus.I2C_SCLK = sclPin;

    i2c_codec_slave dut (
        .iCLK(iCLK),
        .iRST_N(iRST_N),
        .I2C_SDAT(I2C_SDAT),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int driveCnt = 0;
    int busySeen = 0;
    int weWidthErr = 0;
    int weNoDrive = 0;
    logic weLast = 1'b0;
    commit_t gotQ[$];
    logic [7:0] txq[$];

    always @(negedge iCLK) begin
        if (!tbSdaLow && I2C_SDAT === 1'b0) driveCnt++;
        if (bus.oBUSY === 1'b1) busySeen++;
        if (bus.oREG_WE === 1'b1) begin
            gotQ.push_back('{bus.oREG_ADDR, bus.oREG_DATA});
            if (I2C_SDAT !== 1'b0) weNoDrive++;
            if (weLast) weWidthErr++;
        end
        weLast = (bus.oREG_WE === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #2;
        end
    endtask

    task automatic i2cStart();
        tbSdaLow = 1'b0;
        ticks(Q);
        sclPin = 1'b1;
        ticks(Q);
        tbSdaLow = 1'b1;
        ticks(Q);
        sclPin = 1'b0;
    endtask

    task automatic i2cStop(output logic busyAt5, output logic busyAt6);
        ticks(Q);
        tbSdaLow = 1'b1;
        ticks(Q);
        sclPin = 1'b1;
        ticks(Q);
        tbSdaLow = 1'b0;
        ticks(5);
        busyAt5 = bus.oBUSY;
        ticks(1);
        busyAt6 = bus.oBUSY;
        ticks(2 * Q);
    endtask

    // glitch 1: 2-cycle SCL low pulse, glitch 2: 2-cycle SDA flip, both inside the high phase of bit 3
    task automatic sendBits(input logic [7:0] b, input int n, input int glitch);
        for (int i = 7; i > 7 - n; i--) begin
            ticks(Q);
            tbSdaLow = ~b[i];
            ticks(Q);
            sclPin = 1'b1;
            if (glitch != 0 && i == 3) begin
                ticks(Q - 1);
                if (glitch == 1) sclPin = 1'b0; else tbSdaLow = ~tbSdaLow;
                ticks(2);
                if (glitch == 1) sclPin = 1'b1; else tbSdaLow = ~tbSdaLow;
                ticks(Q - 1);
            end else begin
                ticks(2 * Q);
            end
            sclPin = 1'b0;
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input int glitch, input bit haltAtAck,
                            output logic ack, output int ackLat, output int weLat, output logic busyAtAck);
        ack = 1'b0;
        busyAtAck = 1'b0;
        ackLat = -1;
        weLat = -1;
        sendBits(b, 8, glitch);
        tbSdaLow = 1'b0;
        for (int c = 1; c <= 2 * Q; c++) begin
            ticks(1);
            if (ackLat < 0 && I2C_SDAT === 1'b0) ackLat = c;
            if (weLat < 0 && bus.oREG_WE === 1'b1) weLat = c;
            if (haltAtAck && c == 8) return;
        end
        sclPin = 1'b1;
        ticks(Q);
        ack = (I2C_SDAT === 1'b0);
        busyAtAck = bus.oBUSY;
        ticks(Q);
        sclPin = 1'b0;
    endtask

    task automatic runTxn(input string tag, input logic [7:0] bytes[$], input int glitchIdx, input int glitchMode);
        int n;
        int al, wl, lat0, weLat2, drive0, busy0;
        logic ack, ba, b5, b6, addrOk;
        logic [31:0] ackMask, expMask;
        commit_t expQ[$];
        n = bytes.size();
        lat0 = -1;
        weLat2 = -1;
        ackMask = '0;
        drive0 = driveCnt;
        busy0 = busySeen;
        gotQ.delete();
        i2cStart();
        for (int i = 0; i < n; i++) begin
            sendByte(bytes[i], (i == glitchIdx) ? glitchMode : 0, 1'b0, ack, al, wl, ba);
            if (ack) ackMask[i] = 1'b1;
            if (i == 0) lat0 = al;
            if (i == 2) weLat2 = wl;
        end
        i2cStop(b5, b6);

        addrOk = (bytes[0] == 8'h34);
        expMask = addrOk ? ((32'd1 << n) - 32'd1) : 32'd0;
        if (addrOk)
            for (int k = 1; k + 1 < n; k += 2)
                expQ.push_back('{bytes[k][7:1], {bytes[k][0], bytes[k + 1]}});

        check({tag, ".acks"}, ackMask, expMask);
        check({tag, ".commits"}, gotQ.size(), expQ.size());
        foreach (expQ[k]) begin
            if (k < gotQ.size()) begin
                check({tag, ".addr"}, {25'd0, gotQ[k].a}, {25'd0, expQ[k].a});
                check({tag, ".data"}, {23'd0, gotQ[k].d}, {23'd0, expQ[k].d});
            end
        end
        check({tag, ".busy_before_stop"}, {31'd0, b5}, {31'd0, addrOk});
        check({tag, ".busy_after_stop"}, {31'd0, b6}, 32'd0);
        if (addrOk) begin
            check({tag, ".ack_latency"}, lat0, 32'd6);
            if (n >= 3) check({tag, ".we_latency"}, weLat2, 32'd6);
        end else begin
            check({tag, ".sda_never_driven"}, driveCnt - drive0, 32'd0);
            check({tag, ".busy_never"}, busySeen - busy0, 32'd0);
        end
    endtask

    initial begin
        logic ack, ba, b5, b6;
        int al, wl, nb;
        logic [6:0] keepAddr;
        logic [8:0] keepData;

        ticks(3);
        check("rst.sda", {31'd0, I2C_SDAT}, 32'd1);
        check("rst.we", {31'd0, bus.oREG_WE}, 32'd0);
        check("rst.addr", {25'd0, bus.oREG_ADDR}, 32'd0);
        check("rst.data", {23'd0, bus.oREG_DATA}, 32'd0);
        check("rst.busy", {31'd0, bus.oBUSY}, 32'd0);
        iRST_N = 1'b1;
        ticks(10);

        txq = '{8'h34, 8'h1E, 8'h00};
        runTxn("wrA", txq, -1, 0);
        txq = '{8'h34, 8'h05, 8'h79, 8'h08, 8'hF8};
        runTxn("wrB", txq, -1, 0);
        txq = '{8'h36, 8'h11, 8'h22};
        runTxn("badaddr", txq, -1, 0);
        txq = '{8'h35, 8'h11};
        runTxn("readreq", txq, -1, 0);

        // STOP straight after the first data byte is acknowledged
        keepAddr = 7'h04;
        keepData = 9'h0F8;
        gotQ.delete();
        i2cStart();
        sendByte(8'h34, 0, 1'b0, ack, al, wl, ba);
        sendByte(8'h12, 0, 1'b0, ack, al, wl, ba);
        check("early_stop.byte1_ack", {31'd0, ack}, 32'd1);
        i2cStop(b5, b6);
        check("early_stop.no_commit", gotQ.size(), 32'd0);
        check("early_stop.addr_kept", {25'd0, bus.oREG_ADDR}, {25'd0, keepAddr});
        check("early_stop.data_kept", {23'd0, bus.oREG_DATA}, {23'd0, keepData});
        check("early_stop.busy", {31'd0, bus.oBUSY}, 32'd0);

        // repeated START in the middle of the second data byte
        i2cStart();
        sendByte(8'h34, 0, 1'b0, ack, al, wl, ba);
        sendByte(8'h12, 0, 1'b0, ack, al, wl, ba);
        sendBits(8'hAB, 4, 0);
        check("restart.no_partial_commit", gotQ.size(), 32'd0);
        txq = '{8'h34, 8'h0A, 8'h55};
        runTxn("restart", txq, -1, 0);

        txq = '{8'h34, 8'h3C, 8'hA5};
        runTxn("scl_glitch", txq, 1, 1);
        txq = '{8'h34, 8'hC3, 8'h5A};
        runTxn("sda_glitch", txq, 2, 2);

        // a short SDA dip on an idle bus must not be taken as START
        tbSdaLow = 1'b1;
        ticks(2);
        tbSdaLow = 1'b0;
        ticks(Q);
        sclPin = 1'b0;
        sendByte(8'h34, 0, 1'b0, ack, al, wl, ba);
        check("idle_glitch.no_ack", {31'd0, ack}, 32'd0);
        i2cStop(b5, b6);

        for (int t = 0; t < 6; t++) begin
            txq.delete();
            txq.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h34);
            nb = $urandom_range(0, 4);
            for (int j = 0; j < nb; j++) txq.push_back(8'($urandom));
            runTxn($sformatf("rand%0d", t), txq, -1, 0);
        end

        // reset asserted while the slave holds SDA low for the address ACK
        i2cStart();
        sendByte(8'h34, 0, 1'b1, ack, al, wl, ba);
        check("rst_ack.driven", {31'd0, I2C_SDAT}, 32'd0);
        #5 iRST_N = 1'b0;
        #1;
        check("rst_ack.sda_released", {31'd0, I2C_SDAT}, 32'd1);
        check("rst_ack.we", {31'd0, bus.oREG_WE}, 32'd0);
        check("rst_ack.addr", {25'd0, bus.oREG_ADDR}, 32'd0);
        check("rst_ack.data", {23'd0, bus.oREG_DATA}, 32'd0);
        check("rst_ack.busy", {31'd0, bus.oBUSY}, 32'd0);
        sclPin = 1'b1;
        tbSdaLow = 1'b0;
        ticks(10);
        iRST_N = 1'b1;
        ticks(10);

        check("we_width_one_cycle", weWidthErr, 32'd0);
        check("we_with_sda_drive", weNoDrive, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
